// File: rtl/soc_sysid_arbiter.sv
// rtl/soc_sysid_arbiter.sv - two-master round-robin read sequencer for the sysid slave
module soc_sysid_arbiter #(
  parameter int READ_LATENCY = 0,
  parameter int DATA_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_read,
  input  logic              m0_address,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic              m1_read,
  input  logic              m1_address,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              sys_address,
  input  logic [DATA_W-1:0] sys_readdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY);

  state_t     state;
  state_t     state_nxt;
  logic       last_grant;
  logic       owner;
  logic [3:0] lat_cnt;
  logic       grant0;
  logic       grant1;
  logic       capture;

  always_comb begin
    state_nxt        = state;
    grant0           = 1'b0;
    grant1           = 1'b0;
    capture          = 1'b0;
    m0_waitrequest   = 1'b1;
    m1_waitrequest   = 1'b1;
    m0_readdatavalid = 1'b0;
    m1_readdatavalid = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester that did not win last time goes first.
        if (!reset) begin
          if (m0_read && (!m1_read || last_grant)) begin
            grant0 = 1'b1;
          end else if (m1_read) begin
            grant1 = 1'b1;
          end
        end
        m0_waitrequest = !grant0;
        m1_waitrequest = !grant1;
        if (grant0 || grant1) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        m0_readdatavalid = !reset && !owner;
        m1_readdatavalid = !reset && owner;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      lat_cnt     <= 4'd0;
      sys_address <= 1'b0;
      m0_readdata <= '0;
      m1_readdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant0 || grant1) begin
        owner       <= grant1;
        last_grant  <= grant1;
        sys_address <= grant1 ? m1_address : m0_address;
        lat_cnt     <= LAT_INIT;
      end else if (state == WAIT && lat_cnt != 4'd0) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      // The slave has no handshake; its data is trusted only after the settle delay.
      if (capture) begin
        if (owner) begin
          m1_readdata <= sys_readdata;
        end else begin
          m0_readdata <= sys_readdata;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_soc_sysid_arbiter.sv
// tb/tb_soc_sysid_arbiter.sv - randomized model-checked bench for soc_sysid_arbiter
module tb_soc_sysid_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        m0_read = 1'b0;
  logic        m0_address = 1'b0;
  logic        m1_read = 1'b0;
  logic        m1_address = 1'b0;
  logic [31:0] perturb = 32'h0;

  logic [1:0]       w0, w1, v0, v1, sa, bz;
  logic [1:0][31:0] d0, d1, srd;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] slave_word(logic a);
    return (a ? 32'h6256528C : 32'h0000_0000) ^ perturb;
  endfunction

  assign srd[0] = slave_word(sa[0]);
  assign srd[1] = slave_word(sa[1]);

  soc_sysid_arbiter #(.READ_LATENCY(0), .DATA_W(32)) u_l0 (
    .clock(clock), .reset(reset),
    .m0_read(m0_read), .m0_address(m0_address), .m0_waitrequest(w0[0]),
    .m0_readdata(d0[0]), .m0_readdatavalid(v0[0]),
    .m1_read(m1_read), .m1_address(m1_address), .m1_waitrequest(w1[0]),
    .m1_readdata(d1[0]), .m1_readdatavalid(v1[0]),
    .sys_address(sa[0]), .sys_readdata(srd[0]), .busy(bz[0])
  );

  soc_sysid_arbiter #(.READ_LATENCY(3), .DATA_W(32)) u_l3 (
    .clock(clock), .reset(reset),
    .m0_read(m0_read), .m0_address(m0_address), .m0_waitrequest(w0[1]),
    .m0_readdata(d0[1]), .m0_readdatavalid(v0[1]),
    .m1_read(m1_read), .m1_address(m1_address), .m1_waitrequest(w1[1]),
    .m1_readdata(d1[1]), .m1_readdatavalid(v1[1]),
    .sys_address(sa[1]), .sys_readdata(srd[1]), .busy(bz[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: one record per instance, timed by cycles since acceptance.
  int          lat[2] = '{0, 3};
  bit          mb_busy[2];
  bit          m_own[2];
  bit          m_last[2];
  bit          m_addr[2];
  int          m_k[2];
  logic [31:0] m_rd[2][2];
  bit          model_live = 1'b0;

  function automatic int grant_of(int i);
    if (reset || mb_busy[i]) return -1;
    if (m0_read && m1_read) return m_last[i] ? 0 : 1;
    if (m0_read) return 0;
    if (m1_read) return 1;
    return -1;
  endfunction

  initial begin
    forever begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        int    g;
        bit    ev;
        string p;
        g  = grant_of(i);
        ev = !reset && mb_busy[i] && (m_k[i] == lat[i] + 2);
        p  = $sformatf("L%0d", lat[i]);
        if (model_live) begin
          chk({p, " m0_waitrequest"}, w0[i], (g == 0) ? 0 : 1);
          chk({p, " m1_waitrequest"}, w1[i], (g == 1) ? 0 : 1);
          chk({p, " m0_readdatavalid"}, v0[i], ev && !m_own[i]);
          chk({p, " m1_readdatavalid"}, v1[i], ev && m_own[i]);
          chk({p, " m0_readdata"}, d0[i], m_rd[i][0]);
          chk({p, " m1_readdata"}, d1[i], m_rd[i][1]);
          chk({p, " sys_address"}, sa[i], m_addr[i]);
          chk({p, " busy"}, bz[i], mb_busy[i]);
        end
        if (reset) begin
          mb_busy[i] = 0; m_own[i] = 0; m_last[i] = 1; m_addr[i] = 0; m_k[i] = 0;
          m_rd[i][0] = 0; m_rd[i][1] = 0;
        end else if (g >= 0) begin
          mb_busy[i] = 1; m_own[i] = g[0]; m_last[i] = g[0]; m_k[i] = 1;
          m_addr[i] = g[0] ? m1_address : m0_address;
        end else if (mb_busy[i]) begin
          if (m_k[i] == lat[i] + 1) m_rd[i][m_own[i]] = slave_word(m_addr[i]);
          if (m_k[i] == lat[i] + 2) mb_busy[i] = 0;
          else m_k[i]++;
        end
      end
      if (reset) model_live = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle(input int n);
    m0_read = 0;
    m1_read = 0;
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    int cnt;
    int vcyc;
    int grants[$];
    int acc[$];

    reset = 1;
    repeat (3) tick();
    reset = 0;
    tick();

    // m0 reads the timestamp word: L0 valid at T+2, L3 valid at T+5.
    m0_read = 1; m0_address = 1;
    @(negedge clock);
    chk("L0 accept m0", w0[0], 0);
    chk("L3 accept m0", w0[1], 0);
    tick(); m0_read = 0;
    @(negedge clock); chk("L0 no valid T+1", v0[0], 0);
    tick();
    @(negedge clock);
    chk("L0 valid T+2", v0[0], 1);
    chk("L0 data T+2", d0[0], 32'h6256528C);
    chk("L0 m1 untouched valid", v1[0], 0);
    chk("L0 m1 untouched data", d1[0], 32'h0);
    tick(); tick(); tick();
    @(negedge clock);
    chk("L3 valid T+5", v0[1], 1);
    chk("L3 data T+5", d0[1], 32'h6256528C);
    settle(3);

    // m1 reads the ID word on the L3 instance.
    m1_read = 1; m1_address = 0;
    @(negedge clock);
    chk("L3 accept m1", w1[1], 0);
    cnt = 0; vcyc = -1;
    for (int j = 1; j <= 8; j++) begin
      tick(); m1_read = 0;
      @(negedge clock);
      if (bz[1]) cnt++;
      if (v1[1]) vcyc = j;
      if (!w1[1]) vcyc = 100 + j;
    end
    chk("L3 busy cycles", cnt, 5);
    chk("L3 m1 valid cycle", vcyc, 5);
    chk("L3 m1 data", d1[1], 32'h0);
    settle(2);

    // First tie after reset goes to m0, then grants alternate.
    do_reset();
    m0_read = 1; m0_address = 1; m1_read = 1; m1_address = 0;
    for (int j = 0; j < 18; j++) begin
      @(negedge clock);
      if (!w0[0]) grants.push_back(0);
      if (!w1[0]) grants.push_back(1);
      tick();
    end
    chk("tie grant count", grants.size(), 6);
    foreach (grants[k]) chk($sformatf("tie grant %0d", k), grants[k], k % 2);
    settle(6);
    chk("tie m0 data", d0[0], 32'h6256528C);
    chk("tie m1 data", d1[0], 32'h0);

    // Reset while L3 is in WAIT abandons the transaction.
    m0_read = 1; m0_address = 1;
    @(negedge clock); chk("rst test accept", w0[1], 0);
    tick(); m0_read = 0;
    tick(); reset = 1; m0_read = 1; m1_read = 1;
    @(negedge clock);
    chk("rst m0_waitrequest", w0[1], 1);
    chk("rst m1_waitrequest", w1[1], 1);
    tick(); reset = 0; m0_read = 0; m1_read = 0;
    @(negedge clock);
    chk("post-rst busy", bz[1], 0);
    chk("post-rst sys_address", sa[1], 0);
    cnt = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clock);
      if (v0[1] || v1[1]) cnt++;
      tick();
    end
    chk("post-rst no valid", cnt, 0);
    m0_read = 1; m1_read = 1;
    @(negedge clock);
    chk("post-rst tie m0", w0[1], 0);
    chk("post-rst tie m1", w1[1], 1);
    tick();
    settle(6);

    // m0 streams alone while the slave data wanders every cycle.
    m0_read = 1; m0_address = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clock);
      if (!w0[1]) acc.push_back(j);
      tick();
      perturb = $urandom;
    end
    chk("stream accept count", acc.size(), 7);
    for (int k = 1; k < acc.size(); k++) chk($sformatf("stream period %0d", k), acc[k] - acc[k-1], 6);
    settle(6);

    // Random traffic with occasional resets.
    for (int j = 0; j < 800; j++) begin
      if ($urandom_range(0, 3) == 0) begin m0_read = $urandom_range(0, 1); m0_address = $urandom_range(0, 1); end
      if ($urandom_range(0, 3) == 0) begin m1_read = $urandom_range(0, 1); m1_address = $urandom_range(0, 1); end
      reset = ($urandom_range(0, 99) == 0);
      perturb = $urandom;
      tick();
    end
    reset = 0;
    settle(10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/soc_sysid_arbiter.md
Name: soc_sysid_arbiter

Overview:
Two-requester round-robin arbiter and read sequencer in front of the system-ID slave. The slave is a 1-bit-address, read-only, no-handshake control port. The block lets two Avalon-MM masters read the ID word (address 0) and the timestamp word (address 1), one at a time. It adds waitrequest/readdatavalid handshaking and a configurable settle delay before sampling the slave's readdata. It sits between the interconnect master ports (CPU data master, boot/debug master) and the sysid control slave.

Parameters:
READ_LATENCY, 0, extra cycles sys_address is held stable before sys_readdata is sampled; legal range 0..15
DATA_W, 32, read data width

Ports:
clock  in  1  system clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
m0_read  in  1  requester 0 read request
m0_address  in  1  requester 0 word select (0 = ID, 1 = timestamp)
m0_waitrequest  out  1  requester 0 stall; low = request accepted this cycle
m0_readdata  out  DATA_W  requester 0 returned data
m0_readdatavalid  out  1  requester 0 data-valid pulse
m1_read  in  1  requester 1 read request
m1_address  in  1  requester 1 word select
m1_waitrequest  out  1  requester 1 stall
m1_readdata  out  DATA_W  requester 1 returned data
m1_readdatavalid  out  1  requester 1 data-valid pulse
sys_address  out  1  address driven to the sysid slave
sys_readdata  in  DATA_W  sysid slave readdata (combinational)
busy  out  1  high while a transaction is in flight (state != IDLE)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, named clock and reset.
- Reset values:
  - state = IDLE; last_grant = 1 (so m0 wins the first tie); latency counter = 0.
  - sys_address = 0; busy = 0.
  - m*_readdatavalid = 0; m*_readdata = 0.
  - m*_waitrequest = 1 while reset is high.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If exactly one mX_read is high, grant X.
  - If both are high, grant the requester that is not last_grant.
  - The granted master sees mX_waitrequest = 0 combinationally in that cycle; that is acceptance.
  - On the acceptance edge: latch the address into sys_address, record owner, set last_grant = owner, load counter = READ_LATENCY, go to WAIT.
  - The non-granted master, or any master with read low, sees waitrequest = 1.
- WAIT:
  - All waitrequest = 1. sys_address holds the latched value.
  - If counter != 0, decrement.
  - If counter == 0, capture sys_readdata into the owner's readdata register and go to RESP.
- RESP:
  - Owner's readdatavalid = 1 for exactly one cycle; all waitrequest = 1. Next state IDLE.
  - The non-owner's readdata and readdatavalid are unchanged (valid stays 0).
- Latency: acceptance in cycle T gives readdatavalid in cycle T+READ_LATENCY+2.
- Throughput: one transaction per READ_LATENCY+3 cycles; back-to-back alternating grants when both requesters hold read high.
- m*_readdata holds its last captured value until the next capture for that master.
- The master must hold read and address stable while waitrequest = 1 (Avalon rule). A read dropped before acceptance is simply not served; no error.
- sys_address changes only on acceptance edges and holds otherwise, including across IDLE.
- Reset mid-transaction (WAIT or RESP): the transaction is abandoned, no readdatavalid is issued, and all registers return to reset values on that edge.
- The address bit is passed through verbatim; there is no range check.

Test Plan:
- Bench slave model returns 0x00000000 for address 0 and 0x6256528C for address 1. READ_LATENCY=0; m0 reads address 1, accepted in cycle T -> m0_readdatavalid=1 in T+2 only, m0_readdata=0x6256528C, m1 outputs untouched.
- READ_LATENCY=3; m1 reads address 0 -> waitrequest low exactly in the acceptance cycle, busy high for 5 cycles, m1_readdatavalid in T+5 with data 0x00000000.
- First tie after reset: m0 and m1 both read -> m0 granted first, m1 waits and is granted in the next IDLE. Each receives its own address's data; grants alternate m0, m1, m0, ... over 6 transactions.
- m0 requests continuously while m1 is idle -> every transaction goes to m0 with no idle bubbles beyond the IDLE cycle (period READ_LATENCY+3).
- Reset asserted during WAIT -> no readdatavalid; after reset, busy=0, sys_address=0, both waitrequest=1 during reset, and the next tie is granted to m0.
- Slave data changed during WAIT before the capture cycle -> captured value equals sys_readdata in the final WAIT cycle.
